// File: rtl/uart_block_tx.sv
// uart_block_tx: serialises one 128-bit block into 16 UART 8N1 frames on tx,
// most significant byte first, each byte LSB first, with no gap between frames.
module uart_block_tx #(
  parameter int CLOCK_SPEED    = 100000000,
  parameter int BAUD_RATE      = 9600,
  parameter int CLOCKS_PER_BIT = 10417
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic         data_state,
  output logic         tx,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] LAST = 16'(CLOCKS_PER_BIT - 1);
  state_t       state, state_n;
  logic [15:0]  bit_cnt, bit_cnt_n;
  logic [2:0]   bit_idx, bit_idx_n;
  logic [3:0]   byte_idx, byte_idx_n;
  logic [127:0] shift, shift_n;
  logic         prev_state, tx_n, done_n, wrap;
  if (CLOCKS_PER_BIT < 2 || CLOCKS_PER_BIT > 65535 || CLOCK_SPEED <= 0 || BAUD_RATE <= 0) begin : g_bad_params
    $error("uart_block_tx: illegal parameter values");
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      prev_state <= 1'b1;
      tx         <= 1'b1;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      bit_idx    <= bit_idx_n;
      byte_idx   <= byte_idx_n;
      shift      <= shift_n;
      prev_state <= data_state;
      tx         <= tx_n;
      done       <= done_n;
    end
  end
  assign busy = state != IDLE;
  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    shift_n    = shift;
    done_n     = 1'b0;
    wrap       = bit_cnt == LAST;
    bit_cnt_n  = (state == IDLE || wrap) ? 16'd0 : bit_cnt + 16'd1;
    case (state)
      IDLE: if (data_state && !prev_state) begin
        shift_n    = data_in;
        byte_idx_n = 4'd0;
        state_n    = START;
      end
      START: if (wrap) begin
        bit_idx_n = 3'd0;
        state_n   = DATA;
      end
      DATA: if (wrap) begin
        bit_idx_n = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_n = STOP;
      end
      STOP: if (wrap) begin
        if (byte_idx == 4'd15) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          shift_n    = shift << 8;
          byte_idx_n = byte_idx + 4'd1;
          state_n    = START;
        end
      end
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so the line changes exactly on bit boundaries
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[{4'd15, bit_idx_n}] : 1'b1;
  end
endmodule
